cordic_iter_ctrl: RTL and testbench
===================================

// Module: cordic_iter_ctrl
//
// PURPOSE
//   Iteration sequencer for the CORDIC datapath. It consumes the count/tick side of
//   iteration counting: it accepts a start request, latches an iteration count, and
//   issues one load strobe followed by N enable cycles with an ascending iteration
//   index. It terminates on an internal down-counter, then holds a valid/ready
//   result handshake. It sits between the host interface and the CORDIC stage
//   registers.
//
// PARAMETERS
//   Width   5   bit width of iters_i, iter_o and the internal remaining-count register
//
// PORTS
//   clk_i        in   1      clock; all logic on rising edge
//   rst_i        in   1      reset, synchronous, active-high
//   start_i      in   1      start request; sampled only in IDLE
//   iters_i      in   Width  iteration count N; sampled with an accepted start
//   busy_o       out  1      high in every state except IDLE
//   load_o       out  1      one-cycle strobe: datapath loads operands
//   ena_o        out  1      datapath iteration enable; high for exactly N cycles
//   iter_o       out  Width  current iteration index, 0..N-1, valid while ena_o=1
//   out_valid_o  out  1      result valid; held until out_ready_i
//   out_ready_i  in   1      result consumer ready
//   abort_i      in   1      present only with CORDIC_ITER_CTRL_ABORT_EN
//
// BEHAVIOUR
//   - Reset (synchronous, rst_i=1 at clock edge): state=IDLE. busy_o, load_o, ena_o
//     and out_valid_o are 0; iter_o=0; rem=0. Reset mid-operation discards the job.
//   - FSM states: IDLE, LOAD, RUN, DONE. All outputs are registered or decoded from state.
//   - IDLE: if start_i=1, latch n_q<=iters_i and go to LOAD. Otherwise stay in IDLE.
//   - LOAD: load_o=1 for one cycle. rem<=n_q, iter_o<=0.
//     If n_q==0, go to DONE (zero iterations, ena_o never asserted). Otherwise go to RUN.
//   - RUN: ena_o=1. Each cycle rem<=rem-1 and iter_o<=iter_o+1.
//     When rem==1, go to DONE. iter_o is not advanced past N-1.
//   - DONE: out_valid_o=1, iter_o holds N-1 (0 if N==0).
//     If out_ready_i=1, go to IDLE (handshake in the same cycle). Otherwise hold.
//   - Latency: start sampled at edge t; load_o high in cycle t+1; ena_o high in
//     t+2..t+1+N; out_valid_o first high in cycle t+2+N.
//   - A start_i asserted while busy_o=1 is ignored and not queued.
//     start_i in the DONE->IDLE handshake cycle is ignored; it is accepted in IDLE only.
//   - N = 2^Width-1 is supported. rem never wraps: RUN exits at rem==1 before 0.
//   - iters_i changes after acceptance have no effect (n_q is latched).
//
// CONFIGURATION
//   CORDIC_ITER_CTRL_ABORT_EN defined:
//     - Port abort_i exists.
//     - abort_i=1 in LOAD or RUN: next state is IDLE; ena_o/load_o drop next cycle;
//       out_valid_o is never asserted for that job.
//     - abort_i=1 in IDLE or DONE is ignored. rst_i has priority over abort_i.
//   Not defined: no abort_i port; a job always runs to DONE.
//
// TESTING
//   1 reset: rst_i=1 for 2 cycles mid-RUN (N=8) -> next cycle all outputs 0,
//     state IDLE, no out_valid_o.
//   2 nominal: start_i=1, iters_i=16, out_ready_i=1 -> load_o in 1 cycle;
//     ena_o 16 cycles with iter_o 0..15; out_valid_o 1 cycle at t+18; busy_o low after.
//   3 zero/one: iters_i=0 -> no ena_o, out_valid_o at t+2;
//     iters_i=1 -> ena_o 1 cycle (iter_o=0), out_valid_o at t+3.
//   4 backpressure/max: iters_i=31 (Width=5), out_ready_i=0 for 10 cycles ->
//     31 ena_o cycles, out_valid_o held 10 cycles, then drops after ready.
//   5 ignored start: start_i pulses during RUN and in the handshake cycle ->
//     no extra load_o; a new start_i in IDLE is accepted normally.
//   6 abort (macro on): abort_i=1 at iter_o=3 of N=8 -> IDLE next cycle,
//     ena_o low, out_valid_o never asserts; abort_i in DONE is ignored.

Source files
------------

// File: rtl/cordic_iter_ctrl.sv
// CORDIC iteration sequencer: start -> load strobe -> N enable cycles -> result handshake.
// Optional abort input is enabled by defining CORDIC_ITER_CTRL_ABORT_EN.
module cordic_iter_ctrl #(
    parameter int Width = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [Width-1:0] iters_i,
    input  logic             out_ready_i,
`ifdef CORDIC_ITER_CTRL_ABORT_EN
    input  logic             abort_i,
`endif
    output logic             busy_o,
    output logic             load_o,
    output logic             ena_o,
    output logic [Width-1:0] iter_o,
    output logic             out_valid_o
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_e;

    state_e           state_q, state_d;
    logic [Width-1:0] n_q, n_d;
    logic [Width-1:0] rem_q, rem_d;
    logic [Width-1:0] iter_q, iter_d;
    logic             abort;

`ifdef CORDIC_ITER_CTRL_ABORT_EN
    assign abort = abort_i;
`else
    assign abort = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        rem_d   = rem_q;
        iter_d  = iter_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    n_d     = iters_i;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    rem_d   = n_q;
                    iter_d  = '0;
                    state_d = (n_q == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    rem_d = rem_q - Width'(1);
                    // Exit on the last count so iter_o stops at N-1 and rem never wraps
                    if (rem_q == Width'(1)) begin
                        state_d = DONE;
                    end else begin
                        iter_d = iter_q + Width'(1);
                    end
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            n_q     <= '0;
            rem_q   <= '0;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            rem_q   <= rem_d;
            iter_q  <= iter_d;
        end
    end

    assign busy_o      = (state_q != IDLE);
    assign load_o      = (state_q == LOAD);
    assign ena_o       = (state_q == RUN);
    assign out_valid_o = (state_q == DONE);
    assign iter_o      = iter_q;

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// Bench for cordic_iter_ctrl: fixed vector table, directed corner sequences,
// and random traffic against a job-timeline reference model.
module tb_cordic_iter_ctrl;

    localparam int W = 5;

    logic         clk;
    logic         rst_i;
    logic         start_i;
    logic [W-1:0] iters_i;
    logic         out_ready_i;
    logic         abort_v;
    logic         busy_o;
    logic         load_o;
    logic         ena_o;
    logic [W-1:0] iter_o;
    logic         out_valid_o;

    int n_vec;
    int n_err;
    int load_cnt;
    int ena_cnt;
    int valid_cnt;

    // Reference model: a job is a timeline counted in cycles since acceptance.
    // k==1 load, k in 2..N+1 enable with index k-2, k>=N+2 result pending.
    bit m_act;
    int m_k;
    int m_n;
    bit m_iter0;
    bit abort_en;

    cordic_iter_ctrl #(.Width(W)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .iters_i    (iters_i),
        .out_ready_i(out_ready_i),
`ifdef CORDIC_ITER_CTRL_ABORT_EN
        .abort_i    (abort_v),
`endif
        .busy_o     (busy_o),
        .load_o     (load_o),
        .ena_o      (ena_o),
        .iter_o     (iter_o),
        .out_valid_o(out_valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         start;
        logic [W-1:0] iters;
        logic         ready;
        logic         e_busy;
        logic         e_load;
        logic         e_ena;
        logic         e_valid;
        logic         chk_iter;
        logic [W-1:0] e_iter;
    } vec_t;

    vec_t tbl[15];

    task automatic expect_eq(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic check_model(input string tag);
        logic eb, el, ee, ev, ci, ok;
        int ei;
        eb = m_act;
        el = m_act && (m_k == 1);
        ee = m_act && (m_k >= 2) && (m_k <= m_n + 1);
        ev = m_act && (m_k >= m_n + 2);
        ci = 1'b0;
        ei = 0;
        if (ee) begin
            ci = 1'b1;
            ei = m_k - 2;
        end else if (ev) begin
            ci = 1'b1;
            ei = (m_n == 0) ? 0 : m_n - 1;
        end else if (!m_act && m_iter0) begin
            ci = 1'b1;
            ei = 0;
        end
        ok = (busy_o == eb) && (load_o == el) && (ena_o == ee) &&
             (out_valid_o == ev);
        if (ci && (int'(iter_o) != ei)) ok = 1'b0;
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: busy/load/ena/valid/iter got %b%b%b%b/%0d want %b%b%b%b/%0d",
                     tag, busy_o, load_o, ena_o, out_valid_o, iter_o,
                     eb, el, ee, ev, ei);
        end
        if (load_o) load_cnt++;
        if (ena_o) ena_cnt++;
        if (out_valid_o) valid_cnt++;
    endtask

    task automatic model_update();
        if (rst_i) begin
            m_act   = 1'b0;
            m_iter0 = 1'b1;
        end else if (!m_act) begin
            if (start_i) begin
                m_act   = 1'b1;
                m_k     = 1;
                m_n     = int'(iters_i);
                m_iter0 = 1'b0;
            end
        end else if (abort_en && abort_v && (m_k <= m_n + 1)) begin
            m_act = 1'b0;
        end else if (m_k >= m_n + 2) begin
            if (out_ready_i) m_act = 1'b0;
        end else begin
            m_k++;
        end
    endtask

    task automatic step(input string tag, input logic s, input logic [W-1:0] n,
                        input logic r, input logic a, input logic rs);
        @(negedge clk);
        check_model(tag);
        start_i     = s;
        iters_i     = n;
        out_ready_i = r;
        abort_v     = a;
        rst_i       = rs;
        @(posedge clk);
        model_update();
    endtask

    task automatic clr_cnt();
        load_cnt  = 0;
        ena_cnt   = 0;
        valid_cnt = 0;
    endtask

    initial begin
        logic ok;
        n_vec = 0;
        n_err = 0;
        clr_cnt();
`ifdef CORDIC_ITER_CTRL_ABORT_EN
        abort_en = 1'b1;
`else
        abort_en = 1'b0;
`endif
        rst_i       = 1'b1;
        start_i     = 1'b0;
        iters_i     = '0;
        out_ready_i = 1'b0;
        abort_v     = 1'b0;
        repeat (2) @(posedge clk);
        m_act   = 1'b0;
        m_k     = 0;
        m_n     = 0;
        m_iter0 = 1'b1;

        // Fixed table: N=2 with late ready, N=0, N=1, start in handshake cycle.
        tbl[0]  = '{1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0};
        tbl[1]  = '{1'b0, 5'd7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0};
        tbl[2]  = '{1'b0, 5'd7, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0};
        tbl[3]  = '{1'b0, 5'd7, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd1};
        tbl[4]  = '{1'b0, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd1};
        tbl[5]  = '{1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd1};
        tbl[6]  = '{1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0};
        tbl[7]  = '{1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0};
        tbl[8]  = '{1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0};
        tbl[9]  = '{1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0};
        tbl[10] = '{1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0};
        tbl[11] = '{1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0};
        tbl[12] = '{1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0};
        tbl[13] = '{1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0};
        tbl[14] = '{1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0};

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            ok = (busy_o == tbl[i].e_busy) && (load_o == tbl[i].e_load) &&
                 (ena_o == tbl[i].e_ena) && (out_valid_o == tbl[i].e_valid);
            if (tbl[i].chk_iter && (iter_o != tbl[i].e_iter)) ok = 1'b0;
            n_vec++;
            if (!ok) begin
                n_err++;
                $display("FAIL tbl[%0d]: busy/load/ena/valid/iter got %b%b%b%b/%0d want %b%b%b%b/%0d",
                         i, busy_o, load_o, ena_o, out_valid_o, iter_o,
                         tbl[i].e_busy, tbl[i].e_load, tbl[i].e_ena,
                         tbl[i].e_valid, tbl[i].e_iter);
            end
            start_i     = tbl[i].start;
            iters_i     = tbl[i].iters;
            out_ready_i = tbl[i].ready;
            abort_v     = 1'b0;
            rst_i       = 1'b0;
            @(posedge clk);
            model_update();
        end

        // Reset for two cycles in the middle of an N=8 run.
        clr_cnt();
        for (int j = 0; j < 14; j++)
            step("rst_mid_run", j == 0, 5'd8, 1'b1, 1'b0, (j == 4) || (j == 5));
        expect_eq("rst_valid_cnt", valid_cnt, 0);

        // Nominal N=16 with ready held high.
        clr_cnt();
        for (int j = 0; j < 22; j++)
            step("nominal16", j == 0, 5'd16, 1'b1, 1'b0, 1'b0);
        expect_eq("nom_load_cnt", load_cnt, 1);
        expect_eq("nom_ena_cnt", ena_cnt, 16);
        expect_eq("nom_valid_cnt", valid_cnt, 1);

        // Maximum count with the result held under backpressure.
        clr_cnt();
        for (int j = 0; j < 44; j++)
            step("max31_bp", j == 0, 5'd31, j >= 42, 1'b0, 1'b0);
        expect_eq("max_ena_cnt", ena_cnt, 31);
        expect_eq("max_valid_cnt", valid_cnt, 10);
        expect_eq("max_busy_after", int'(busy_o), 0);

        // Starts during RUN and in the handshake cycle are dropped.
        clr_cnt();
        for (int j = 0; j < 9; j++)
            step("ign_start", (j == 0) || (j == 3) || (j == 6) || (j == 7),
                 5'd4, j == 6, 1'b0, 1'b0);
        expect_eq("ign_load_cnt", load_cnt, 2);
        for (int j = 0; j < 8; j++)
            step("ign_drain", 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);

`ifdef CORDIC_ITER_CTRL_ABORT_EN
        // Abort at iteration 3 of 8, then abort while a result is pending.
        clr_cnt();
        for (int j = 0; j < 16; j++)
            step("abort_run", j == 0, 5'd8, 1'b1, j == 5, 1'b0);
        expect_eq("abort_valid_cnt", valid_cnt, 0);
        expect_eq("abort_ena_cnt", ena_cnt, 4);
        clr_cnt();
        for (int j = 0; j < 6; j++)
            step("abort_done", j == 0, 5'd0, j == 4, j == 2, 1'b0);
        expect_eq("abort_done_valid", valid_cnt, 3);
`endif

        // Random traffic, mostly short jobs with occasional long ones.
        for (int j = 0; j < 3000; j++) begin
            logic [W-1:0] n;
            n = ($urandom_range(0, 7) == 0) ? W'($urandom_range(0, 31))
                                            : W'($urandom_range(0, 5));
            step("random", $urandom_range(0, 2) == 0, n,
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 19) == 0,
                 $urandom_range(0, 99) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
